// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU sequencer: opcodes, one-hot states,
// error codes and the opcode legality check.
package uart_alu_pkg;

    localparam int NB_OPCODE = 6;

    localparam logic [NB_OPCODE-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OPCODE-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OPCODE-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OPCODE-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OPCODE-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OPCODE-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OPCODE-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OPCODE-1:0] OP_SRL = 6'b000010;

    localparam logic [4:0] ST_WAIT_A  = 5'b00001;
    localparam logic [4:0] ST_WAIT_B  = 5'b00010;
    localparam logic [4:0] ST_WAIT_OP = 5'b00100;
    localparam logic [4:0] ST_COMPUTE = 5'b01000;
    localparam logic [4:0] ST_WAIT_TX = 5'b10000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BAD_OP  = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    function automatic logic is_legal_op(input logic [NB_OPCODE-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tick_timeout.sv
// Counts baud ticks while enabled; o_done flags the tick that reaches TIMEOUT_TICKS.
module tick_timeout #(
    parameter int TIMEOUT_TICKS = 2048,
    parameter int NB_TMO        = 12
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    logic [NB_TMO-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Flag the terminal tick itself so a byte in the same cycle can still win.
    assign o_done = i_enable && (r_cnt == NB_TMO'(TIMEOUT_TICKS - 1));

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B and opcode bytes from the UART, runs them through the ALU and
// sends the result back, flagging timeouts, bad opcodes and overruns.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA       = 8,
    parameter int NB_OP         = 6,
    parameter int TIMEOUT_TICKS = 2048,
    parameter int NB_TMO        = 12
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err,
    output logic [1:0]         o_err_code
);

    logic [4:0]         r_state;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_tx_start;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic               w_counting;
    logic               w_busy;
    logic               w_tmo;
    logic [NB_OP-1:0]   w_op;

    assign w_counting = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_busy     = (r_state == ST_COMPUTE) || (r_state == ST_WAIT_TX);
    assign w_op       = i_rx_data[NB_OP-1:0];

    tick_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .NB_TMO        (NB_TMO)
    ) u_tick_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (!w_counting || i_rx_valid || w_tmo),
        .i_enable (i_tick && w_counting),
        .o_done   (w_tmo)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_WAIT_A;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            // NOTE: pulse outputs default low each cycle so they last exactly one clock.
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_WAIT_A: if (i_rx_valid) begin
                    r_alu_a <= i_rx_data;
                    r_state <= ST_WAIT_B;
                end
                ST_WAIT_B: if (i_rx_valid) begin
                    r_alu_b <= i_rx_data;
                    r_state <= ST_WAIT_OP;
                end else if (w_tmo) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_TIMEOUT;
                    r_state    <= ST_WAIT_A;
                end
                ST_WAIT_OP: if (i_rx_valid) begin
                    if (is_legal_op(w_op)) begin
                        r_alu_op <= w_op;
                        r_state  <= ST_COMPUTE;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_BAD_OP;
                        r_state    <= ST_WAIT_A;
                    end
                end else if (w_tmo) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_TIMEOUT;
                    r_state    <= ST_WAIT_A;
                end
                ST_COMPUTE: begin
                    r_tx_data  <= i_alu_result;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_WAIT_TX;
                end
                // A done pulse alongside our own start belongs to a previous frame.
                ST_WAIT_TX: if (i_tx_done && !r_tx_start) begin
                    r_state <= ST_WAIT_A;
                end
                default: r_state <= ST_WAIT_A;
            endcase
            if (i_rx_valid && w_busy) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_OVERRUN;
            end
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = w_busy;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed plus randomized checks of uart_alu_ctrl against a command-level model.
module tb_uart_alu_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_tick = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_err;
    logic [1:0] o_err_code;

    int checks = 0;
    int failures = 0;

    logic [5:0] legal_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000011, 6'b000010};

    // Command-level expectations: last accepted opcode and last error code.
    logic [5:0] m_op = '0;
    logic [1:0] m_code = '0;

    uart_alu_ctrl dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000011: return 8'($signed(a) >>> b);
            6'b000010: return a >> b;
            default:   return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    function automatic logic legal_ref(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        cyc();
        i_rx_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check(tag, 64'({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy,
                        o_err, o_err_code}), 64'(0));
    endtask

    task automatic tick_pulses(input int n, inout logic seen);
        repeat (n) begin
            i_tick = 1'b1;
            cyc();
            i_tick = 1'b0;
            seen |= o_err;
            cyc();
            seen |= o_err;
        end
    endtask

    // Sends one full command and, for legal opcodes, completes the transmit frame.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gap);
        logic [5:0] op;
        logic [7:0] res;
        op = opb[5:0];
        send(a);
        check("a_latched", 64'(o_alu_a), 64'(a));
        repeat (gap) cyc();
        send(b);
        check("b_latched", 64'(o_alu_b), 64'(b));
        check("no_err_b", 64'(o_err), 64'(0));
        repeat (gap) cyc();
        send(opb);
        if (legal_ref(op)) begin
            res = alu_ref(a, b, op);
            check("op_latched", 64'(o_alu_op), 64'(op));
            check("compute_busy", 64'({o_busy, o_tx_start, o_err}), 64'(3'b100));
            i_tx_done = 1'b1;
            cyc();
            check("tx_start", 64'(o_tx_start), 64'(1));
            check("tx_data", 64'(o_tx_data), 64'(res));
            cyc();
            i_tx_done = 1'b0;
            check("done_ignored", 64'({o_busy, o_tx_start}), 64'(2'b10));
            repeat (gap) cyc();
            i_tx_done = 1'b1;
            cyc();
            i_tx_done = 1'b0;
            check("tx_done_idle", 64'(o_busy), 64'(0));
            m_op = op;
        end else begin
            m_code = 2'b10;
            check("bad_op_err", 64'({o_err, o_err_code, o_busy}), 64'(4'b1100));
            check("bad_op_keep", 64'(o_alu_op), 64'(m_op));
            cyc();
            check("bad_op_no_tx", 64'({o_tx_start, o_err, o_busy}), 64'(0));
        end
        check("err_code_held", 64'(o_err_code), 64'(m_code));
    endtask

    initial begin
        logic seen;
        logic [7:0] held_tx;
        logic [7:0] opb;

        // Reset with bytes and done pulses arriving.
        for (int i = 0; i < 3; i++) begin
            i_rx_valid = (i != 1);
            i_rx_data  = 8'hAA;
            i_tx_done  = 1'b1;
            cyc();
            check_zero("reset_hold");
        end
        i_rx_valid = 1'b0;
        i_tx_done  = 1'b0;
        i_reset    = 1'b1;
        cyc();
        check_zero("reset_release");

        // ADD 5 + 3.
        run_cmd(8'h05, 8'h03, 8'h20, 0);
        check("add_result", 64'(o_tx_data), 64'(8'h08));

        // Illegal opcode, then SUB 0x0A - 0x04.
        run_cmd(8'h01, 8'h02, 8'h3F, 0);
        run_cmd(8'h0A, 8'h04, 8'h22, 1);
        check("sub_result", 64'(o_tx_data), 64'(8'h06));

        // No timeout while idle in WAIT_A.
        seen = 1'b0;
        tick_pulses(2100, seen);
        check("no_tmo_idle", 64'(seen), 64'(0));

        // Timeout after 2048 ticks in WAIT_B.
        send(8'h11);
        seen = 1'b0;
        tick_pulses(2047, seen);
        check("no_tmo_2047", 64'(seen), 64'(0));
        i_tick = 1'b1;
        cyc();
        i_tick = 1'b0;
        m_code = 2'b01;
        check("tmo_err", 64'({o_err, o_err_code}), 64'(3'b101));
        cyc();
        check("tmo_pulse_end", 64'(o_err), 64'(0));
        send(8'h5A);
        check("tmo_back_to_a", 64'(o_alu_a), 64'(8'h5A));

        // Byte on the 2048th tick wins.
        seen = 1'b0;
        tick_pulses(2047, seen);
        i_tick     = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h33;
        cyc();
        i_tick     = 1'b0;
        i_rx_valid = 1'b0;
        check("race_no_err", 64'({seen, o_err, o_err_code}), 64'(4'b0001));
        check("race_b", 64'(o_alu_b), 64'(8'h33));
        send(8'h24);
        check("race_in_wait_op", 64'({o_busy, o_alu_op}), 64'({1'b1, 6'b100100}));
        m_op = 6'b100100;
        cyc();
        check("race_tx", 64'({o_tx_start, o_tx_data}), 64'({1'b1, 8'h5A & 8'h33}));

        // Overrun during WAIT_TX.
        held_tx = o_tx_data;
        send(8'h77);
        m_code = 2'b11;
        check("ovr_err", 64'({o_err, o_err_code, o_busy}), 64'(4'b1111));
        check("ovr_keep", 64'({o_tx_data, o_alu_a}), 64'({held_tx, 8'h5A}));
        i_tx_done = 1'b1;
        cyc();
        i_tx_done = 1'b0;
        check("ovr_idle", 64'({o_busy, o_err}), 64'(0));
        send(8'h42);
        check("ovr_next_a", 64'(o_alu_a), 64'(8'h42));

        // Reset in WAIT_OP.
        send(8'h43);
        i_reset = 1'b0;
        cyc();
        i_reset = 1'b1;
        check_zero("rst_wait_op");

        // Reset in WAIT_TX, then a late done pulse.
        send(8'h09);
        send(8'h02);
        send(8'h25);
        cyc();
        check("pre_rst_tx", 64'(o_tx_start), 64'(1));
        i_reset = 1'b0;
        cyc();
        i_reset = 1'b1;
        check_zero("rst_wait_tx");
        m_op = '0;
        m_code = '0;
        i_tx_done = 1'b1;
        cyc();
        i_tx_done = 1'b0;
        check_zero("late_done");
        run_cmd(8'hC3, 8'h02, 8'h03, 0);
        check("post_rst_sra", 64'(o_tx_data), 64'(8'hF0));

        // Randomized commands.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1)
                opb = {2'($urandom), legal_ops[$urandom_range(0, 7)]};
            else
                opb = 8'($urandom);
            run_cmd(8'($urandom), 8'($urandom), opb, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
